// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared FSM encoding and width constants for the wishbone data slave.
package wb_pkg;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;
endpackage

// File: rtl/wb_slave_ram.sv
// rtl/wb_slave_ram.sv - DEPTH x DW storage, byte-enabled synchronous write, registered synchronous read.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [SEL_W-1:0] be,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/wb_data_slave.sv
// rtl/wb_data_slave.sv - Wishbone classic single-transfer slave with WAIT_STATES latency over a byte-lane RAM.
// Optional WB_SLAVE_ERR_EN: out-of-range addresses terminate with ERR_O instead of wrapping.
module wb_data_slave
    import wb_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    input  logic [ADDR_WIDTH-1:0]  ADR_I,
    input  logic [SEL_W-1:0]       SEL_I,
    input  logic [DATA_LENGTH-1:0] DAT_I,
    output logic [DATA_LENGTH-1:0] DAT_O,
    output logic                   ACK_O,
    output logic                   ERR_O
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [RAM_AW-1:0]      adr_q;
    logic                   we_q;
    logic [SEL_W-1:0]       sel_q;
    logic [DATA_LENGTH-1:0] dat_q;
    logic                   oor_q;
    logic                   err_q;

    logic                   req;
    logic                   oor_in;
    logic                   fire;
    logic [RAM_AW-1:0]      t_adr;
    logic                   t_we;
    logic [SEL_W-1:0]       t_sel;
    logic [DATA_LENGTH-1:0] t_dat;
    logic                   t_oor;
    logic                   ram_we;
    logic                   ram_re;

    assign req = CYC_I & STB_I;

`ifdef WB_SLAVE_ERR_EN
    assign oor_in = ({1'b0, ADR_I} >= (ADDR_WIDTH+1)'(DEPTH));
    assign ERR_O  = err_q;
`else
    logic unused_sig;
    assign oor_in     = 1'b0;
    assign ERR_O      = 1'b0;
    assign unused_sig = ^{err_q, ADR_I};
`endif

    // With zero wait states the memory is accessed on the sampling edge itself,
    // so the request fields come straight from the bus rather than the latches.
    always_comb begin
        t_adr = adr_q;
        t_we  = we_q;
        t_sel = sel_q;
        t_dat = dat_q;
        t_oor = oor_q;
        if (state == IDLE) begin
            t_adr = ADR_I[RAM_AW-1:0];
            t_we  = WE_I;
            t_sel = SEL_I;
            t_dat = DAT_I;
            t_oor = oor_in;
        end
    end

    assign fire   = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                    ((state == WAIT) && CYC_I && (cnt == '0));
    assign ram_we = !reset && fire && t_we && !t_oor;
    assign ram_re = !reset && fire && !t_we && !t_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            oor_q <= 1'b0;
            ACK_O <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ACK_O <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        adr_q <= ADR_I[RAM_AW-1:0];
                        we_q  <= WE_I;
                        sel_q <= SEL_I;
                        dat_q <= DAT_I;
                        oor_q <= oor_in;
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                            ACK_O <= !oor_in;
                            err_q <= oor_in;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!CYC_I) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= ACK;
                        ACK_O <= !oor_q;
                        err_q <= oor_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    wb_slave_ram #(
        .DW    (DATA_LENGTH),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (t_adr),
        .be    (t_sel),
        .wdata (t_dat),
        .rdata (DAT_O)
    );
endmodule

// File: tb/tb_wb_data_slave.sv
// tb/tb_wb_data_slave.sv - self-checking bench: three slaves (0/1/3 wait states) against a transaction-level model.
module tb_wb_data_slave;
    import wb_pkg::*;

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat = '0;
    int          cur = 0;
    logic [31:0] dato [3];
    logic        ack [3];
    logic        err [3];

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_data_slave #(
            .DATA_LENGTH (32),
            .ADDR_WIDTH  (8),
            .DEPTH       (64),
            .WAIT_STATES ((g == 2) ? 3 : g)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .CYC_I (cyc && (cur == g)),
            .STB_I (stb),
            .WE_I  (we),
            .ADR_I (adr),
            .SEL_I (sel),
            .DAT_I (dat),
            .DAT_O (dato[g]),
            .ACK_O (ack[g]),
            .ERR_O (err[g])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endfunction

    // Transaction-level model: a request sampled at edge k terminates at edge k+ws,
    // the following edge is never sampled, and dropping CYC before then abandons it.
    int          ws [3] = '{0, 1, 3};
    int          k = 0;
    bit          busy [3];
    int          due [3];
    int          nxt [3];
    logic [7:0]  p_adr [3];
    bit          p_we [3];
    logic [3:0]  p_sel [3];
    logic [31:0] p_dat [3];
    logic [31:0] mm [3][64];
    bit          mk [3][64];
    bit          e_ack [3];
    bit          e_err [3];
    logic [31:0] e_dat [3];
    bit          e_dk [3];

    task automatic model_finish(input int d);
        int a;
        a = p_adr[d] % 64;
        busy[d] = 1'b0;
        nxt[d]  = k + 2;
        if (ERR_EN && p_adr[d] >= 64) begin
            e_err[d] = 1'b1;
        end else begin
            e_ack[d] = 1'b1;
            if (p_we[d]) begin
                for (int b = 0; b < 4; b++)
                    if (p_sel[d][b]) mm[d][a][8*b +: 8] = p_dat[d][8*b +: 8];
                if (p_sel[d] == 4'hF) mk[d][a] = 1'b1;
            end else begin
                e_dat[d] = mm[d][a];
                e_dk[d]  = mk[d][a];
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            busy[d] = 1'b0; nxt[d] = 0; e_ack[d] = 1'b0; e_err[d] = 1'b0;
            e_dat[d] = '0; e_dk[d] = 1'b0;
            for (int a = 0; a < 64; a++) mk[d][a] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int d = 0; d < 3; d++) begin
                    busy[d] = 1'b0; nxt[d] = 0; e_ack[d] = 1'b0; e_err[d] = 1'b0;
                    e_dat[d] = '0; e_dk[d] = 1'b1;
                end
            end else begin
                k++;
                for (int d = 0; d < 3; d++) begin
                    e_ack[d] = 1'b0;
                    e_err[d] = 1'b0;
                    if (busy[d]) begin
                        if (!(cyc && cur == d)) begin
                            busy[d] = 1'b0;
                            nxt[d]  = k + 1;
                        end else if (k == due[d]) begin
                            model_finish(d);
                        end
                    end else if (cyc && stb && cur == d && k >= nxt[d]) begin
                        p_adr[d] = adr; p_we[d] = we; p_sel[d] = sel; p_dat[d] = dat;
                        busy[d] = 1'b1;
                        due[d]  = k + ws[d];
                        if (ws[d] == 0) model_finish(d);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("ack%0d", d), {31'b0, ack[d]}, {31'b0, e_ack[d]});
                chk($sformatf("err%0d", d), {31'b0, err[d]}, {31'b0, e_err[d]});
                chk($sformatf("ackerr%0d", d), {31'b0, ack[d] & err[d]}, 32'd0);
                if (e_dk[d]) chk($sformatf("dat%0d", d), dato[d], e_dat[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic w, input logic [7:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
        cur = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = wd;
    endtask

    // Called just after a rising edge; returns once the termination cycle has passed.
    task automatic xfer(input string name, input int d, input logic w, input logic [7:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input bit keep,
                        output int lat, output logic [31:0] rd, output logic got_err);
        bit done;
        done = 1'b0; lat = 0; rd = '0; got_err = 1'b0;
        drive(d, w, a, s, wd);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (ack[d] || err[d]) begin
                done = 1'b1; rd = dato[d]; got_err = err[d];
            end
        end
        if (!done) begin
            total++;
            $display("FAIL %s: no termination within 40 cycles", name);
        end
        tick();
        if (!keep) begin cyc = 1'b0; stb = 1'b0; end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        ge;
    int          nack;

    initial begin
        #3 reset = 1'b1;
        tick();
        checking = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ack%0d", d), {31'b0, ack[d]}, 32'd0);
            chk($sformatf("rst_dat%0d", d), dato[d], 32'd0);
        end
        tick();
        reset = 1'b0;
        tick();

        xfer("wr5", 1, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 1'b0, lat, rd, ge);
        chk("wr5_lat", lat, 32'd3);
        xfer("rd5", 1, 1'b0, 8'd5, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        chk("rd5_lat", lat, 32'd3);
        chk("rd5_dat", rd, 32'hDEADBEEF);

        xfer("pre3", 1, 1'b1, 8'd3, 4'hF, 32'h11223344, 1'b0, lat, rd, ge);
        xfer("lane3", 1, 1'b1, 8'd3, 4'b0101, 32'hAABBCCDD, 1'b0, lat, rd, ge);
        xfer("rd3", 1, 1'b0, 8'd3, 4'b0000, 32'h0, 1'b0, lat, rd, ge);
        chk("lane_dat", rd, 32'h11BB33DD);
        xfer("sel0", 1, 1'b1, 8'd3, 4'b0000, 32'hFFFFFFFF, 1'b0, lat, rd, ge);
        chk("sel0_lat", lat, 32'd3);
        xfer("rd3b", 1, 1'b0, 8'd3, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        chk("sel0_dat", rd, 32'h11BB33DD);

        xfer("pre6", 1, 1'b1, 8'd6, 4'hF, 32'h66666666, 1'b0, lat, rd, ge);
        xfer("wr70", 1, 1'b1, 8'd70, 4'hF, 32'h70707070, 1'b0, lat, rd, ge);
        chk("oor_err", {31'b0, ge}, {31'b0, ERR_EN});
        chk("oor_lat", lat, 32'd3);
        xfer("rd6", 1, 1'b0, 8'd6, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        chk("oor_dat6", rd, ERR_EN ? 32'h66666666 : 32'h70707070);

        xfer("pre12", 2, 1'b1, 8'd12, 4'hF, 32'h0C0C0C0C, 1'b0, lat, rd, ge);
        chk("ws3_lat", lat, 32'd5);
        drive(2, 1'b1, 8'd12, 4'hF, 32'hBAD0BAD0);
        tick();
        tick();
        cyc = 1'b0; stb = 1'b0;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[2] || err[2]) nack++;
        end
        chk("abort_noack", nack, 32'd0);
        tick();
        xfer("rd12", 2, 1'b0, 8'd12, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        chk("abort_lat", lat, 32'd5);
        chk("abort_dat", rd, 32'h0C0C0C0C);

        for (int i = 0; i < 3; i++)
            xfer("pre2x", 0, 1'b1, 8'(20 + i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b0, lat, rd, ge);
        for (int i = 0; i < 3; i++) begin
            xfer("b2b", 0, 1'b0, 8'(20 + i), 4'hF, 32'h0, i < 2, lat, rd, ge);
            chk($sformatf("b2b_lat%0d", i), lat, 32'd2);
            chk($sformatf("b2b_dat%0d", i), rd, 32'hC0DE0000 + 32'(i));
        end

        xfer("pre9", 2, 1'b1, 8'd9, 4'hF, 32'h01234567, 1'b0, lat, rd, ge);
        xfer("rd9", 2, 1'b0, 8'd9, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        drive(2, 1'b1, 8'd9, 4'hF, 32'hFFFFFFFF);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", {31'b0, ack[2]}, 32'd0);
        chk("rst_mid_dat", dato[2], 32'd0);
        chk("rst_mid_state", {30'b0, g_dut[2].u_dut.state}, {30'b0, IDLE});
        cyc = 1'b0; stb = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        xfer("rd9b", 2, 1'b0, 8'd9, 4'hF, 32'h0, 1'b0, lat, rd, ge);
        chk("rst_keep9", rd, 32'h01234567);

        repeat (3) tick();
        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_data_slave.md
WB_DATA_SLAVE -- requirements
Module: wb_data_slave

Interface
REQ-001 Parameter DATA_LENGTH, 32, data bus width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, 8, word-address width of ADR_I.
REQ-003 Parameter DEPTH, 64, number of 32-bit words stored; SHALL be a power of two, no greater than 2**ADDR_WIDTH.
REQ-004 Parameter WAIT_STATES, 1, extra cycles inserted before acknowledge; range 0..15.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 CYC_I  input  1  bus cycle in progress.
REQ-008 STB_I  input  1  strobe; request valid when CYC_I&STB_I.
REQ-009 WE_I  input  1  1 = write, 0 = read.
REQ-010 ADR_I  input  ADDR_WIDTH  word address.
REQ-011 SEL_I  input  4  byte-lane enables; bit n covers DAT_I[8n+7:8n].
REQ-012 DAT_I  input  DATA_LENGTH  write data.
REQ-013 DAT_O  output  DATA_LENGTH  read data, registered.
REQ-014 ACK_O  output  1  normal termination, registered, one-cycle pulse.
REQ-015 ERR_O  output  1  error termination, registered, one-cycle pulse; tied 0 when REQ-027 is not compiled in.

Function
REQ-016 The block SHALL be a Wishbone classic single-transfer slave with FSM states IDLE, WAIT, ACK.
REQ-017 IDLE: on a rising edge with CYC_I&STB_I=1, the block SHALL latch ADR_I, WE_I, SEL_I and DAT_I, then go to ACK if WAIT_STATES=0, else go to WAIT with its counter loaded to WAIT_STATES-1.
REQ-018 WAIT: the counter SHALL decrement each cycle; at 0 the block SHALL go to ACK on the next edge.
REQ-019 Acknowledge latency: ACK_O SHALL be high during exactly the cycle after edge N+WAIT_STATES, where N is the sampling edge of the request.
REQ-020 A write SHALL update only the bytes whose SEL_I bit was set, on the edge entering ACK; SEL_I=0000 SHALL write nothing but still acknowledge.
REQ-021 A read SHALL load DAT_O with the full addressed word on the edge entering ACK, independent of SEL_I.
REQ-022 DAT_O SHALL hold its value outside read acknowledges, including across writes.
REQ-023 ACK: the block SHALL return to IDLE unconditionally and SHALL NOT sample a new request in the ACK cycle, so there is at least one IDLE cycle between transfers.
REQ-024 Abort: if CYC_I=0 in WAIT, the block SHALL return to IDLE with no memory write, no DAT_O change and no ACK_O/ERR_O.
REQ-025 ACK_O and ERR_O SHALL never be high in the same cycle.

Reset
REQ-026 While reset=1, the block SHALL be in IDLE with the counter at 0, ACK_O=0, ERR_O=0 and DAT_O=0, immediately and regardless of clk; memory contents are not reset, and reset mid-transfer discards the transfer.

Configuration
REQ-027 With WB_SLAVE_ERR_EN defined, a request with ADR_I>=DEPTH SHALL be terminated by ERR_O at the REQ-019 timing instead of ACK_O, with no write and DAT_O unchanged.
REQ-028 Without WB_SLAVE_ERR_EN, the address SHALL be taken modulo DEPTH (low log2(DEPTH) bits) and acknowledged normally, and ERR_O SHALL be constant 0.

Structure
REQ-029 A shared package wb_pkg SHALL hold the FSM state encoding, the SEL width constant (4) and the WAIT_STATES counter width constant (4).
REQ-030 The storage SHALL be the sub-module wb_slave_ram: DEPTH x 32, synchronous write with per-byte enables, synchronous read.

Verification
REQ-031 Reset: assert reset mid-WAIT of a write -> ACK_O=0, DAT_O=0, state IDLE; a later read of that address returns its pre-write content.
REQ-032 WAIT_STATES=1: write 0xDEADBEEF to address 5 with SEL=1111 -> ACK_O high exactly 2 cycles after the sampling edge; a later read of address 5 -> DAT_O=0xDEADBEEF with ACK_O.
REQ-033 Byte lanes: preload address 3 with 0x11223344, write 0xAABBCCDD with SEL=0101 -> a later read returns 0x11BB33DD.
REQ-034 Abort: write request with WAIT_STATES=3, drop CYC_I after 1 cycle -> no ACK_O, memory unchanged; the next request is accepted from IDLE.
REQ-035 Out of range, DEPTH=64, write to address 70: with WB_SLAVE_ERR_EN -> ERR_O pulse and memory unchanged; without it -> ACK_O pulse and address 6 written.
REQ-036 Back-to-back: STB_I held high across 3 reads with WAIT_STATES=0 -> ACK_O pulses separated by exactly one IDLE cycle, DAT_O correct on each.
